button_event_ctrl: RTL and testbench

- Front-end controller for the front-panel buttons of the brainfuck machine (step, run, reset-PC, mode).
- Synchronizes and debounces N raw buttons, runs a per-button auto-repeat FSM, and schedules press, repeat and release events.
- Events go to the CPU/UI sequencer through a single valid/ready event port.
- A round-robin arbiter shares the one event port among all buttons.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_chan.sv | 116 +++++++++++
 rtl/button_event_ctrl.sv | 96 +++++++++
 tb/tb_button_event_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the front-panel button event controller.
// Event kinds, repeat FSM states and the event-code width helper.
package btn_pkg;

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_REPEAT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } rpt_state_t;

  function automatic int code_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button: sync, debounce, auto-repeat FSM and a single pending event slot.
// The slot reports a dropped press/release; repeats coalesce silently.
module btn_chan
  import btn_pkg::*;
#(
  parameter int CTR_WIDTH     = 16,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 12000000,
  parameter int REPEAT_PERIOD = 3000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_raw,
  input  logic       i_grant,
  output logic       o_state,
  output logic       o_slot_valid,
  output logic [1:0] o_slot_kind,
  output logic       o_drop
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic                 r_s1, r_s2, r_state;
  logic [CTR_WIDTH-1:0] r_cnt;
  logic                 w_diff, w_acc, w_press, w_rel;

  assign w_diff  = r_s2 ^ r_state;
  assign w_acc   = w_diff && (&r_cnt);
  assign w_press = w_acc && r_s2;
  assign w_rel   = w_acc && !r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (!w_diff || w_acc) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 1'b1;
      if (w_acc) r_state <= r_s2;
    end
  end

  rpt_state_t    r_fsm, w_fsm_nxt;
  logic [RW-1:0] r_rcnt, w_rcnt_nxt;
  logic          w_rpt;

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_rcnt_nxt = r_rcnt;
    w_rpt      = 1'b0;
    unique case (r_fsm)
      S_IDLE: begin
        if (w_press && (REPEAT_EN != 0)) begin
          w_fsm_nxt  = S_DELAY;
          w_rcnt_nxt = RW'(REPEAT_DELAY - 1);
        end
      end
      S_DELAY, S_REPEAT: begin
        if (w_rel) begin
          w_fsm_nxt = S_IDLE;
        end else if (r_rcnt == '0) begin
          w_rpt      = 1'b1;
          w_fsm_nxt  = S_REPEAT;
          w_rcnt_nxt = RW'(REPEAT_PERIOD - 1);
        end else begin
          w_rcnt_nxt = r_rcnt - 1'b1;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm  <= S_IDLE;
      r_rcnt <= '0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_rcnt <= w_rcnt_nxt;
    end
  end

  logic       w_ev;
  logic [1:0] w_kind;
  logic       r_sv;
  logic [1:0] r_sk;

  assign w_ev   = w_acc || w_rpt;
  assign w_kind = w_press ? EV_PRESS :
                  w_rel   ? EV_RELEASE : EV_REPEAT;

  // A granted slot frees up this cycle, so it may take a new event at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sv <= 1'b0;
      r_sk <= EV_PRESS;
    end else if (w_ev && (!r_sv || i_grant)) begin
      r_sv <= 1'b1;
      r_sk <= w_kind;
    end else if (i_grant) begin
      r_sv <= 1'b0;
    end
  end

  assign o_drop       = w_ev && r_sv && !i_grant && (w_kind != EV_REPEAT);
  assign o_state      = r_state;
  assign o_slot_valid = r_sv;
  assign o_slot_kind  = r_sk;

endmodule

// File: rtl/button_event_ctrl.sv
// Button front end: N debounced channels sharing one valid/ready event port
// through a round-robin arbiter, plus a sticky lost-event flag.
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter  int N_BTN         = 4,
  parameter  int CTR_WIDTH     = 16,
  parameter  int REPEAT_EN     = 1,
  parameter  int REPEAT_DELAY  = 12000000,
  parameter  int REPEAT_PERIOD = 3000000,
  localparam int CW            = code_w(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CW-1:0]    ev_code,
  output logic [1:0]       ev_kind,
  output logic             ev_ovf,
  input  logic             ovf_clr
);

  logic [N_BTN-1:0] w_sv, w_grant, w_drop;
  logic [1:0]       w_sk [N_BTN];

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_chan #(
      .CTR_WIDTH    (CTR_WIDTH),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_raw       (btn_raw[g]),
      .i_grant     (w_grant[g]),
      .o_state     (btn_state[g]),
      .o_slot_valid(w_sv[g]),
      .o_slot_kind (w_sk[g]),
      .o_drop      (w_drop[g])
    );
  end

  logic          r_v, r_ovf;
  logic [CW-1:0] r_code, r_ptr, w_idx;
  logic [1:0]    r_kind;
  logic          w_any, w_load;

  assign w_load = !r_v || ev_ready;

  // Walk from farthest to nearest so the slot right after r_ptr wins.
  always_comb begin
    int unsigned k;
    k       = 0;
    w_any   = 1'b0;
    w_idx   = '0;
    w_grant = '0;
    for (int i = N_BTN; i >= 1; i--) begin
      k = (int'(r_ptr) + i) % N_BTN;
      if (w_sv[k]) begin
        w_any = 1'b1;
        w_idx = CW'(k);
      end
    end
    if (w_load && w_any) w_grant[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= 1'b0;
      r_code <= '0;
      r_kind <= EV_PRESS;
      r_ptr  <= CW'(N_BTN - 1);
      r_ovf  <= 1'b0;
    end else begin
      if (w_load) begin
        r_v <= w_any;
        if (w_any) begin
          r_code <= w_idx;
          r_kind <= w_sk[w_idx];
          r_ptr  <= w_idx;
        end
      end
      if (ovf_clr)      r_ovf <= 1'b0;
      else if (|w_drop) r_ovf <= 1'b1;
    end
  end

  assign ev_valid = r_v;
  assign ev_code  = r_code;
  assign ev_kind  = r_kind;
  assign ev_ovf   = r_ovf;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random button/ready
// traffic, all compared each cycle against an event-level reference model.
module tb_button_event_ctrl;
  import btn_pkg::*;

  localparam int N    = 4;
  localparam int CTRW = 4;
  localparam int DB   = 1 << CTRW;
  localparam int RD   = 40;
  localparam int RP   = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_state;
  logic         ev_valid, ev_ready = 1'b1;
  logic [1:0]   ev_code, ev_kind;
  logic         ev_ovf, ovf_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .N_BTN        (N),
    .CTR_WIDTH    (CTRW),
    .REPEAT_EN    (1),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_state(btn_state),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_kind  (ev_kind),
    .ev_ovf   (ev_ovf),
    .ovf_clr  (ovf_clr)
  );

  // Reference model: levels, run lengths of disagreement, accept times.
  bit         m_s1 [N], m_s2 [N], m_st [N], m_sv [N];
  int         m_run [N], m_acc [N];
  logic [1:0] m_sk [N];
  int         m_ptr, m_code, m_t;
  logic [1:0] m_kind;
  bit         m_v, m_ovf;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_sv[i] = 0;
      m_run[i] = 0; m_acc[i] = -1; m_sk[i] = EV_PRESS;
    end
    m_ptr = N - 1; m_code = 0; m_kind = EV_PRESS;
    m_v = 0; m_ovf = 0; m_t = 0;
  endtask

  // Advances the model across one rising edge using pre-edge inputs.
  task automatic model_step();
    int best, d;
    bit load, drop, gen;
    logic [1:0] gk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_t++;
    best = -1;
    for (int i = 1; i <= N; i++)
      if (best < 0 && m_sv[(m_ptr + i) % N]) best = (m_ptr + i) % N;
    load = !m_v || ev_ready;
    if (load) begin
      m_v = (best >= 0);
      if (best >= 0) begin
        m_code = best; m_kind = m_sk[best]; m_ptr = best;
      end
    end
    drop = 0;
    for (int i = 0; i < N; i++) begin
      gen = 0; gk = EV_PRESS;
      m_run[i] = (m_s2[i] != m_st[i]) ? m_run[i] + 1 : 0;
      if (m_run[i] == DB) begin
        m_run[i] = 0; gen = 1; m_st[i] = m_s2[i];
        gk = m_s2[i] ? EV_PRESS : EV_RELEASE;
        m_acc[i] = m_s2[i] ? m_t : -1;
      end else if (m_acc[i] >= 0) begin
        d = m_t - m_acc[i];
        if (d >= RD && (d - RD) % RP == 0) begin
          gen = 1; gk = EV_REPEAT;
        end
      end
      if (gen && (!m_sv[i] || (load && best == i))) begin
        m_sv[i] = 1; m_sk[i] = gk;
      end else if (gen) begin
        if (gk != EV_REPEAT) drop = 1;
      end else if (load && best == i) begin
        m_sv[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = btn_raw[i];
    end
    if (ovf_clr)   m_ovf = 0;
    else if (drop) m_ovf = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] m_state();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_st[i];
    return r;
  endfunction

  task automatic cyc(input int n);
    for (int c = 0; c < n; c++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("m_state", btn_state, m_state());
      chk("m_valid", ev_valid, m_v);
      chk("m_code", ev_code, m_code);
      chk("m_kind", ev_kind, m_kind);
      chk("m_ovf", ev_ovf, m_ovf);
    end
  endtask

  task automatic ev_chk(input string tag, input int v, input int code,
                        input int kind);
    chk({tag, "_v"}, ev_valid, v);
    if (v != 0) begin
      chk({tag, "_code"}, ev_code, code);
      chk({tag, "_kind"}, ev_kind, kind);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, tfirst, trel;
    int rq[$];
    model_reset();
    cyc(3);
    rst_n = 1'b1;
    chk("rst_state", btn_state, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_kind", ev_kind, 0);
    chk("rst_ovf", ev_ovf, 0);

    // Clean press/release on button 2.
    btn_raw[2] = 1'b1;
    cyc(17); chk("cp_st17", btn_state[2], 0);
    cyc(1);  chk("cp_st18", btn_state[2], 1); chk("cp_v18", ev_valid, 0);
    cyc(1);  ev_chk("cp_press", 1, 2, EV_PRESS);
    cyc(1);  chk("cp_1cyc", ev_valid, 0);
    cyc(10);
    btn_raw[2] = 1'b0;
    cyc(18); chk("cr_v18", ev_valid, 0);
    cyc(1);  ev_chk("cp_rel", 1, 2, EV_RELEASE);
    cyc(3);

    // Bounce on button 1, then a clean rise.
    cnt = 0;
    for (int p = 0; p < 12; p++) begin
      btn_raw[1] = (p % 2 == 0);
      for (int c = 0; c < 5; c++) begin
        cyc(1);
        cnt += int'(ev_valid);
      end
    end
    chk("bn_quiet", cnt, 0);
    btn_raw[1] = 1'b1;
    cnt = 0; tfirst = -1;
    for (int c = 1; c <= 45; c++) begin
      cyc(1);
      if (ev_valid && ev_code == 1 && ev_kind == EV_PRESS) begin
        cnt++;
        if (tfirst < 0) tfirst = c;
      end
      if (c == 20) btn_raw[1] = 1'b0;
    end
    chk("bn_npress", cnt, 1);
    chk("bn_tpress", tfirst, 19);

    // Auto-repeat on button 0.
    btn_raw[0] = 1'b1;
    cyc(18);
    trel = -1;
    for (int c = 1; c <= 110; c++) begin
      cyc(1);
      if (ev_valid && ev_code == 0 && ev_kind == EV_REPEAT) rq.push_back(c);
      if (ev_valid && ev_code == 0 && ev_kind == EV_RELEASE) trel = c;
      if (c == 80) btn_raw[0] = 1'b0;
    end
    chk("ar_nrep", rq.size(), 6);
    foreach (rq[k]) chk("ar_trep", rq[k], 41 + 10 * k);
    chk("ar_trel", trel, 99);

    // Simultaneous presses and releases from a fresh pointer.
    do_reset();
    btn_raw = 4'b1011;
    cyc(18); chk("sm_v18", ev_valid, 0);
    cyc(1);  ev_chk("sm_p0", 1, 0, EV_PRESS);
    cyc(1);  ev_chk("sm_p1", 1, 1, EV_PRESS);
    cyc(1);  ev_chk("sm_p3", 1, 3, EV_PRESS);
    cyc(1);  chk("sm_idle", ev_valid, 0);
    cyc(8);
    btn_raw = 4'b0000;
    cyc(18); chk("sm_rv18", ev_valid, 0);
    cyc(1);  ev_chk("sm_r0", 1, 0, EV_RELEASE);
    cyc(1);  ev_chk("sm_r1", 1, 1, EV_RELEASE);
    cyc(1);  ev_chk("sm_r3", 1, 3, EV_RELEASE);
    cyc(3);

    // Backpressure: hold btn 0, tap btn 2, port blocked.
    ev_ready = 1'b0;
    btn_raw = 4'b0101;
    for (int c = 1; c <= 100; c++) begin
      cyc(1);
      if (c == 25) btn_raw[2] = 1'b0;
      if (c >= 19) ev_chk("bp_hold", 1, 0, EV_PRESS);
      if (c == 42) chk("bp_ovf42", ev_ovf, 0);
      if (c == 43) chk("bp_ovf43", ev_ovf, 1);
    end
    chk("bp_ovf", ev_ovf, 1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("bp_clr", ev_ovf, 0);
    ev_ready = 1'b1;
    btn_raw[0] = 1'b0;
    cyc(1); ev_chk("bp_d2", 1, 2, EV_PRESS);
    cyc(1); ev_chk("bp_d0", 1, 0, EV_REPEAT);
    cyc(40);

    // Reset while button 3 is held with an event on the port.
    do_reset();
    btn_raw = 4'b1000;
    cyc(19); ev_chk("rh_pre", 1, 3, EV_PRESS);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rh_state", btn_state, 0);
    chk("rh_valid", ev_valid, 0);
    chk("rh_code", ev_code, 0);
    chk("rh_kind", ev_kind, 0);
    chk("rh_ovf", ev_ovf, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(18); chk("rh_v18", ev_valid, 0);
    cyc(1);  ev_chk("rh_press", 1, 3, EV_PRESS);
    btn_raw = '0;
    cyc(30);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(24, 0) == 0)
        btn_raw[$urandom_range(N - 1, 0)] ^= 1'b1;
      ev_ready = ($urandom_range(3, 0) != 0);
      ovf_clr  = ($urandom_range(49, 0) == 0);
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
